seq_scan_ctrl: RTL and testbench
================================

// Module: seq_scan_ctrl
// PURPOSE
//   Run controller for serial pattern detection (default 11011). Accepts a start command with a
//   scan configuration, gates the serial bitstream into a Moore-style matcher and counts hits.
//   Ends the scan on a hit limit or a bit-window timeout. Sits between the stream source and
//   the host/sequencer that arms scans and reads back results.
// PARAMETERS
//   PAT_W    5          pattern length in bits (2..16)
//   PATTERN  5'b11011   pattern; MSB is the first bit received
//   OVERLAP  1          1: overlapping matches; 0: matcher history cleared after each hit
//   CNT_W    8          width of hit counter and of cfg_max_hits
//   WIN_W    12         width of bit-window counter and of cfg_window
// PORTS
//   clk           in   1      clock, rising edge
//   rst           in   1      asynchronous, active-high reset
//   start         in   1      begin scan; accepted in IDLE or DONE only
//   abort         in   1      terminate scan; any state -> IDLE
//   cfg_max_hits  in   CNT_W  hit limit, sampled on accepted start; 0 = no limit
//   cfg_window    in   WIN_W  valid-bit budget, sampled on accepted start; 0 = no limit
//   in            in   1      serial data bit
//   in_valid      in   1      in is meaningful this cycle
//   busy          out  1      high in SCAN
//   done          out  1      high in DONE; held until the next start or abort
//   hit           out  1      one-cycle Moore pulse per detected pattern
//   hit_count     out  CNT_W  hits in the current/last scan
//   timed_out     out  1      DONE was reached by window exhaustion
// BEHAVIOUR
//   Reset: state=IDLE; busy=done=hit=timed_out=0; hit_count=0; matcher history and fill cleared.
//   FSM: IDLE, SCAN, DONE.
//   - IDLE/DONE + start (abort=0): capture cfg; clear hit_count, bits_seen, timed_out and matcher
//     -> SCAN; busy=1 from the next cycle. start in SCAN is ignored.
//   - SCAN: in_valid=1 shifts in `in`, bits_seen+1, fill saturates at PAT_W. in_valid=0 holds all
//     state. in and in_valid are ignored outside SCAN.
//   - Match: shifted history == PATTERN and fill reaches PAT_W at that edge. At that same edge:
//     hit<=1 for one cycle, hit_count+1 (saturating). OVERLAP=0 also clears fill.
//     Visible latency: 1 cycle after the completing bit.
//   - SCAN -> DONE at the same edge on either condition:
//       (a) cfg_max_hits!=0 and the new hit_count == cfg_max_hits;
//       (b) cfg_window!=0 and the new bits_seen == cfg_window -> timed_out=1.
//     (a) and (b) together: timed_out=0 (hit limit wins). The final hit pulse is still emitted.
//   - Both cfg values 0: scan runs until abort.
//   - abort (highest priority, any state) -> IDLE: busy=done=0; hit_count and timed_out held.
//     A hit completing on the abort edge is discarded: no pulse, no count.
//   - start and abort in the same cycle: abort wins.
//   - Async rst mid-scan: immediate return to reset values; no partial results kept.
//   - hit_count saturates at 2^CNT_W-1.
// STRUCTURE
//   Shared package seq_scan_pkg: state encoding localparams (IDLE/SCAN/DONE), default PATTERN.
//   Sub-module seq_match_core:
//   - PAT_W shift register, fill counter, OVERLAP handling;
//   - combinational match_now; shift/clear strobes driven by the controller.
//   The top holds the FSM, counters, config registers and registered outputs.
// TESTING
//   1 Reset: rst=1 at time 0 -> all outputs 0; start asserted during rst is ignored.
//   2 OVERLAP=1, caps 0, stream 110110111011 -> hit pulses after bits 5, 8, 12; hit_count=3;
//     busy stays 1.
//   3 OVERLAP=0, same stream -> hits after bits 5 and 12 only; hit_count=2.
//   4 cfg_max_hits=2, stream from 2 -> DONE at the bit-8 edge; done=1, busy=0, timed_out=0;
//     later bits do not change hit_count.
//   5 cfg_window=4, stream 1101, then 1 -> DONE after bit 4, timed_out=1, hit_count=0.
//     cfg_window=5 with 11011 -> hit, hit_count=1, timed_out=1.
//     cfg_window=5, cfg_max_hits=1, 11011 -> timed_out=0.
//   6 Bubbles and abort:
//     - in_valid gaps inside 11011 -> single hit.
//     - abort on the edge of bit 5 -> no hit, IDLE, hit_count=0.
//     - start+abort together -> stays IDLE.

Source files
------------

// File: rtl/seq_scan_pkg.sv
// seq_scan_pkg: shared state encoding and default pattern for the scan controller
package seq_scan_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [4:0] DEF_PATTERN = 5'b11011;
endpackage

// File: rtl/seq_match_core.sv
// seq_match_core: serial shift-history matcher with fill tracking and optional overlap
module seq_match_core
  import seq_scan_pkg::*;
#(
  parameter int PAT_W = 5,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter bit OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic shift,
  input  logic bit_in,
  output logic match_now
);
  localparam int FW = $clog2(PAT_W + 1);
  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_nxt;
  logic [FW-1:0] fill;
  assign hist_nxt = {hist[PAT_W-2:0], bit_in};
  assign match_now = shift && (hist_nxt == PATTERN) && (fill >= FW'(PAT_W - 1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= hist_nxt;
      fill <= (match_now && !OVERLAP) ? '0 : (fill == FW'(PAT_W)) ? fill : fill + FW'(1);
    end
  end
endmodule

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: scan run controller gating a serial stream into a pattern matcher and counting hits
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int PAT_W = 5,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter bit OVERLAP = 1'b1,
  parameter int CNT_W = 8,
  parameter int WIN_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_max_hits,
  input  logic [WIN_W-1:0] cfg_window,
  input  logic             in,
  input  logic             in_valid,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic [CNT_W-1:0] hit_count,
  output logic             timed_out
);
  logic [1:0] state;
  logic [CNT_W-1:0] max_r;
  logic [WIN_W-1:0] win_r;
  logic [WIN_W-1:0] bits_seen;
  logic [WIN_W-1:0] bits_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic accept;
  logic shift;
  logic match;
  logic lim_hit;
  logic win_hit;
  assign accept = start && !abort && (state != SCAN);
  assign shift = (state == SCAN) && in_valid && !abort;
  assign bits_nxt = bits_seen + WIN_W'(1);
  assign cnt_nxt = (match && hit_count != '1) ? hit_count + CNT_W'(1) : hit_count;
  assign lim_hit = (max_r != '0) && (cnt_nxt == max_r);
  assign win_hit = (win_r != '0) && (bits_nxt == win_r);
  assign busy = state == SCAN;
  assign done = state == DONE;
  seq_match_core #(
    .PAT_W(PAT_W),
    .PATTERN(PATTERN),
    .OVERLAP(OVERLAP)
  ) u_core (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .shift(shift),
    .bit_in(in),
    .match_now(match)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      max_r <= '0;
      win_r <= '0;
      bits_seen <= '0;
      hit_count <= '0;
      hit <= 1'b0;
      timed_out <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      hit <= 1'b0;
    end else if (accept) begin
      state <= SCAN;
      max_r <= cfg_max_hits;
      win_r <= cfg_window;
      bits_seen <= '0;
      hit_count <= '0;
      hit <= 1'b0;
      timed_out <= 1'b0;
    end else if (shift) begin
      bits_seen <= bits_nxt;
      hit_count <= cnt_nxt;
      hit <= match;
      timed_out <= win_hit && !lim_hit;
      state <= (lim_hit || win_hit) ? DONE : SCAN;
    end else begin
      hit <= 1'b0;
    end
  end
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb_seq_scan_ctrl: directed self-checking bench for overlapping and non-overlapping scan controllers
module tb_seq_scan_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic abort;
  logic [7:0] cfg_max_hits;
  logic [11:0] cfg_window;
  logic din;
  logic in_valid;
  logic busy1, done1, hit1, to1;
  logic busy0, done0, hit0, to0;
  logic [7:0] cnt1, cnt0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  seq_scan_ctrl #(.OVERLAP(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_max_hits(cfg_max_hits), .cfg_window(cfg_window),
    .in(din), .in_valid(in_valid),
    .busy(busy1), .done(done1), .hit(hit1), .hit_count(cnt1), .timed_out(to1)
  );
  seq_scan_ctrl #(.OVERLAP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_max_hits(cfg_max_hits), .cfg_window(cfg_window),
    .in(din), .in_valid(in_valid),
    .busy(busy0), .done(done0), .hit(hit0), .hit_count(cnt0), .timed_out(to0)
  );
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(input logic [7:0] m, input logic [11:0] w);
    cfg_max_hits = m;
    cfg_window = w;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy1", busy1, 1);
    chk("start_busy0", busy0, 1);
  endtask
  task automatic send_bit(input logic b, input logic e1, input logic e0);
    din = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("hit_ovl", hit1, e1);
    chk("hit_novl", hit0, e0);
  endtask
  task automatic gap();
    din = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("gap_hit_ovl", hit1, 0);
    chk("gap_hit_novl", hit0, 0);
  endtask
  task automatic send_stream(input logic [15:0] bits, input int n, input logic [15:0] e1, input logic [15:0] e0);
    for (int i = n - 1; i >= 0; i--) send_bit(bits[i], e1[i], e0[i]);
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b1;
    abort = 1'b0;
    cfg_max_hits = 8'd0;
    cfg_window = 12'd0;
    din = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_hit", hit1, 0);
    chk("rst_cnt", cnt1, 0);
    chk("rst_to", to1, 0);
    rst = 1'b0;
    start = 1'b0;
    tick();
    chk("idle_busy", busy1, 0);
    // overlapping vs non-overlapping, no caps
    do_start(8'd0, 12'd0);
    chk("s2_cnt0", cnt1, 0);
    send_stream(16'b110110111011, 12, 16'b000010010001, 16'b000010000001);
    tick();
    chk("s2_cnt_ovl", cnt1, 3);
    chk("s2_cnt_novl", cnt0, 2);
    chk("s2_busy", busy1, 1);
    chk("s2_done", done1, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy1, 0);
    chk("abort_done", done1, 0);
    chk("abort_cnt_held", cnt1, 3);
    // hit limit 2
    do_start(8'd2, 12'd0);
    send_stream(16'b11011011, 8, 16'b00001001, 16'b00001000);
    chk("lim_done", done1, 1);
    chk("lim_busy", busy1, 0);
    chk("lim_to", to1, 0);
    chk("lim_cnt", cnt1, 2);
    chk("lim_novl_busy", busy0, 1);
    send_stream(16'b1011, 4, 16'b0000, 16'b0001);
    chk("lim_cnt_after", cnt1, 2);
    chk("lim_novl_cnt", cnt0, 2);
    chk("lim_novl_done", done0, 1);
    // window 4
    do_start(8'd0, 12'd4);
    send_stream(16'b1101, 4, 16'b0000, 16'b0000);
    chk("win4_done", done1, 1);
    chk("win4_to", to1, 1);
    chk("win4_cnt", cnt1, 0);
    send_bit(1'b1, 1'b0, 1'b0);
    chk("win4_cnt_after", cnt1, 0);
    // window 5, hit on last bit
    do_start(8'd0, 12'd5);
    send_stream(16'b11011, 5, 16'b00001, 16'b00001);
    chk("win5_cnt", cnt1, 1);
    chk("win5_to", to1, 1);
    chk("win5_done", done1, 1);
    // window 5 and limit 1 together
    do_start(8'd1, 12'd5);
    send_stream(16'b11011, 5, 16'b00001, 16'b00001);
    chk("both_done", done1, 1);
    chk("both_to", to1, 0);
    chk("both_cnt", cnt1, 1);
    // bubbles inside the pattern
    do_start(8'd0, 12'd0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    gap();
    send_bit(1'b0, 1'b0, 1'b0);
    gap();
    gap();
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b1);
    gap();
    chk("bub_cnt", cnt1, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    // abort on the completing edge
    do_start(8'd0, 12'd0);
    send_stream(16'b1101, 4, 16'b0000, 16'b0000);
    din = 1'b1;
    in_valid = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    chk("ab5_hit", hit1, 0);
    chk("ab5_busy", busy1, 0);
    chk("ab5_cnt", cnt1, 0);
    tick();
    chk("ab5_hit_late", hit1, 0);
    // start with abort stays idle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", busy1, 0);
    chk("sa_done", done1, 0);
    // async reset mid-scan
    do_start(8'd0, 12'd0);
    send_stream(16'b110111, 6, 16'b000010, 16'b000010);
    chk("ar_cnt_before", cnt1, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_busy", busy1, 0);
    chk("ar_cnt", cnt1, 0);
    rst = 1'b0;
    tick();
    chk("ar_idle", busy1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
